// File: rtl/ysyx_23060203_flush_ctrl.sv
// Writeback flush sequencer: drain bus traffic, invalidate icache/TLB, then redirect the IFU.
// Optional perf counters under `ifdef YSYX_23060203_FLUSH_PERF_EN.
//   state    | meaning
//   IDLE     | waiting for a flush request from WBU
//   DRAIN    | frontend killed, waiting for IFU/LSU bus traffic to finish
//   FLUSH    | icache/TLB invalidate handshakes in flight (shared timeout)
//   REDIRECT | offering redirect_pc to the IFU
module ysyx_23060203_flush_ctrl #(
  parameter int ACK_TIMEOUT = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_dnpc,
  input  logic        req_icache,
  input  logic        req_tlb,
  output logic        busy,
  output logic        pipe_kill,
  input  logic        ifu_idle,
  input  logic        lsu_idle,
  output logic        icache_flush_req,
  input  logic        icache_flush_ack,
  output logic        tlb_flush_req,
  input  logic        tlb_flush_ack,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        flush_err
`ifdef YSYX_23060203_FLUSH_PERF_EN
  ,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_REDIRECT} state_e;

  localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        icache_q, icache_d;
  logic        tlb_q, tlb_d;
  logic        icache_done_q, icache_done_d;
  logic        tlb_done_q, tlb_done_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        icache_done_nxt, tlb_done_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      icache_q      <= 1'b0;
      tlb_q         <= 1'b0;
      icache_done_q <= 1'b0;
      tlb_done_q    <= 1'b0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      icache_q      <= icache_d;
      tlb_q         <= tlb_d;
      icache_done_q <= icache_done_d;
      tlb_done_q    <= tlb_done_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign pipe_kill        = (state_q == S_DRAIN) || (state_q == S_FLUSH);
  assign icache_flush_req = (state_q == S_FLUSH) && icache_q && !icache_done_q;
  assign tlb_flush_req    = (state_q == S_FLUSH) && tlb_q && !tlb_done_q;
  assign redirect_valid   = (state_q == S_REDIRECT);
  assign redirect_pc      = pc_q;
  assign flush_err        = err_q;

  // An ack only counts while its own request is being driven.
  assign icache_done_nxt = icache_done_q || (icache_flush_req && icache_flush_ack);
  assign tlb_done_nxt    = tlb_done_q || (tlb_flush_req && tlb_flush_ack);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    icache_d      = icache_q;
    tlb_d         = tlb_q;
    icache_done_d = icache_done_q;
    tlb_done_d    = tlb_done_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          pc_d          = req_dnpc;
          icache_d      = req_icache;
          tlb_d         = req_tlb;
          icache_done_d = 1'b0;
          tlb_done_d    = 1'b0;
          state_d       = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ifu_idle && lsu_idle) begin
          cnt_d   = '0;
          state_d = (icache_q || tlb_q) ? S_FLUSH : S_REDIRECT;
        end
      end
      S_FLUSH: begin
        icache_done_d = icache_done_nxt;
        tlb_done_d    = tlb_done_nxt;
        cnt_d         = cnt_q + 16'd1;
        // A final ack landing on the timeout cycle still counts as success.
        if ((!icache_q || icache_done_nxt) && (!tlb_q || tlb_done_nxt)) begin
          state_d = S_REDIRECT;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        if (redirect_ready) begin
          icache_d      = 1'b0;
          tlb_d         = 1'b0;
          icache_done_d = 1'b0;
          tlb_done_d    = 1'b0;
          cnt_d         = '0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef YSYX_23060203_FLUSH_PERF_EN
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_flush_d = perf_flush_q;
    perf_stall_d = perf_stall_q;
    if (redirect_valid && redirect_ready) perf_flush_d = perf_flush_q + 32'd1;
    if (busy) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_flush_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_flush_q <= perf_flush_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_flush_cnt = perf_flush_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset && busy && req_valid)
      $error("flush_ctrl: req_valid asserted while busy; request dropped");
  end
`endif

endmodule

// File: tb/tb_ysyx_23060203_flush_ctrl.sv
// Vector-table bench for ysyx_23060203_flush_ctrl (ACK_TIMEOUT=8) with an expected-output queue.
module tb_ysyx_23060203_flush_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_icache, req_tlb;
  logic [31:0] req_dnpc;
  logic        busy, pipe_kill, ifu_idle, lsu_idle;
  logic        icache_flush_req, icache_flush_ack, tlb_flush_req, tlb_flush_ack;
  logic        redirect_valid, redirect_ready, flush_err;
  logic [31:0] redirect_pc;
`ifdef YSYX_23060203_FLUSH_PERF_EN
  logic [31:0] perf_flush_cnt, perf_stall_cnt;
`endif

  ysyx_23060203_flush_ctrl #(.ACK_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_dnpc(req_dnpc), .req_icache(req_icache), .req_tlb(req_tlb),
    .busy(busy), .pipe_kill(pipe_kill), .ifu_idle(ifu_idle), .lsu_idle(lsu_idle),
    .icache_flush_req(icache_flush_req), .icache_flush_ack(icache_flush_ack),
    .tlb_flush_req(tlb_flush_req), .tlb_flush_ack(tlb_flush_ack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush_err(flush_err)
`ifdef YSYX_23060203_FLUSH_PERF_EN
    , .perf_flush_cnt(perf_flush_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  // in = {req ic tlb ifu_idle lsu_idle ic_ack tlb_ack ready}
  // ex = {busy kill ic_req tlb_req redirect_valid flush_err}; pc checked only when redirect_valid expected
  typedef struct {
    logic [7:0]  in;
    logic [31:0] dnpc;
    logic [5:0]  ex;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic [5:0]  ex;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   split_a;

  localparam logic [7:0] IN_IDLE = 8'b0_0_0_1_1_0_0_0;

  function automatic vec_t v(logic [7:0] in, logic [31:0] dnpc, logic [5:0] ex, logic [31:0] pc);
    vec_t r;
    r.in = in; r.dnpc = dnpc; r.ex = ex; r.pc = pc;
    return r;
  endfunction

  task automatic apply_vec(input int idx, input vec_t t);
    exp_t e;
    logic [5:0] got;
    @(negedge clock);
    {req_valid, req_icache, req_tlb, ifu_idle, lsu_idle,
     icache_flush_ack, tlb_flush_ack, redirect_ready} = t.in;
    req_dnpc = t.dnpc;
    exp_q.push_back('{ex: t.ex, pc: t.pc});
    #1;
    e   = exp_q.pop_front();
    got = {busy, pipe_kill, icache_flush_req, tlb_flush_req, redirect_valid, flush_err};
    checks++;
    if (got != e.ex || (e.ex[1] && redirect_pc != e.pc)) begin
      errors++;
      $display("FAIL vec%0d: got flags=%b pc=%h, want flags=%b pc=%h", idx, got, redirect_pc, e.ex, e.pc);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    // plain redirect, no flush
    vecs.push_back(v(8'b1_0_0_1_1_0_0_0, 32'h8000_0100, 6'b000000, 32'h0));
    vecs.push_back(v(IN_IDLE,            32'h0,         6'b110000, 32'h0));
    vecs.push_back(v(8'b0_0_0_1_1_0_0_1, 32'h0,         6'b100010, 32'h8000_0100));
    vecs.push_back(v(IN_IDLE,            32'h0,         6'b000000, 32'h0));
    // icache+tlb, ack at +3 / +5; stray tlb ack during DRAIN ignored
    vecs.push_back(v(8'b1_1_1_1_1_0_0_0, 32'h8000_0200, 6'b000000, 32'h0));
    vecs.push_back(v(8'b0_0_0_1_1_0_1_0, 32'h0,         6'b110000, 32'h0));
    vecs.push_back(v(IN_IDLE,            32'h0,         6'b111100, 32'h0));
    vecs.push_back(v(8'b0_0_0_1_1_1_0_0, 32'h0,         6'b111100, 32'h0));
    vecs.push_back(v(8'b0_0_0_1_1_1_0_0, 32'h0,         6'b110100, 32'h0));
    vecs.push_back(v(8'b0_0_0_1_1_0_1_0, 32'h0,         6'b110100, 32'h0));
    vecs.push_back(v(8'b0_0_0_1_1_0_0_1, 32'h0,         6'b100010, 32'h8000_0200));
    vecs.push_back(v(IN_IDLE,            32'h0,         6'b000000, 32'h0));
    // lsu busy 10 cycles, ifu busy briefly at the end
    vecs.push_back(v(8'b1_1_0_1_0_0_0_0, 32'h8000_0300, 6'b000000, 32'h0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(v(8'b0_0_0_1_0_0_0_0, 32'h0, 6'b110000, 32'h0));
    vecs.push_back(v(8'b0_0_0_0_0_0_0_0, 32'h0, 6'b110000, 32'h0));
    vecs.push_back(v(8'b0_0_0_0_0_0_0_0, 32'h0, 6'b110000, 32'h0));
    vecs.push_back(v(8'b0_0_0_0_1_0_0_0, 32'h0, 6'b110000, 32'h0));
    vecs.push_back(v(IN_IDLE,            32'h0, 6'b110000, 32'h0));
    vecs.push_back(v(8'b0_0_0_1_1_1_0_0, 32'h0, 6'b111000, 32'h0));
    vecs.push_back(v(8'b0_0_0_1_1_0_0_1, 32'h0, 6'b100010, 32'h8000_0300));
    vecs.push_back(v(IN_IDLE,            32'h0, 6'b000000, 32'h0));
    // tlb only, ack in first request cycle; icache ack without request ignored
    vecs.push_back(v(8'b1_0_1_1_1_0_0_0, 32'h8000_0500, 6'b000000, 32'h0));
    vecs.push_back(v(IN_IDLE,            32'h0,         6'b110000, 32'h0));
    vecs.push_back(v(8'b0_0_0_1_1_1_1_0, 32'h0,         6'b110100, 32'h0));
    vecs.push_back(v(8'b0_0_0_1_1_0_0_1, 32'h0,         6'b100010, 32'h8000_0500));
    vecs.push_back(v(IN_IDLE,            32'h0,         6'b000000, 32'h0));
    // icache ack never arrives: 8 request cycles, then error + redirect held 5 cycles
    vecs.push_back(v(8'b1_1_0_1_1_0_0_0, 32'h8000_0400, 6'b000000, 32'h0));
    vecs.push_back(v(IN_IDLE,            32'h0,         6'b110000, 32'h0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(v(8'b0_0_0_1_1_0_1_0, 32'h0, 6'b111000, 32'h0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(IN_IDLE, 32'h0, 6'b100011, 32'h8000_0400));
    vecs.push_back(v(8'b0_0_0_1_1_0_0_1, 32'h0, 6'b100011, 32'h8000_0400));
    vecs.push_back(v(IN_IDLE,            32'h0, 6'b000001, 32'h0));
    // error stays set across a later clean flush
    vecs.push_back(v(8'b1_0_0_1_1_0_0_0, 32'h8000_0600, 6'b000001, 32'h0));
    vecs.push_back(v(IN_IDLE,            32'h0,         6'b110001, 32'h0));
    vecs.push_back(v(8'b0_0_0_1_1_0_0_1, 32'h0,         6'b100011, 32'h8000_0600));
    vecs.push_back(v(IN_IDLE,            32'h0,         6'b000001, 32'h0));
    split_a = vecs.size();
    // after the mid-FLUSH reset: normal request, error cleared
    vecs.push_back(v(8'b1_0_0_1_1_0_0_0, 32'h8000_0800, 6'b000000, 32'h0));
    vecs.push_back(v(IN_IDLE,            32'h0,         6'b110000, 32'h0));
    vecs.push_back(v(8'b0_0_0_1_1_0_0_1, 32'h0,         6'b100010, 32'h8000_0800));
    vecs.push_back(v(IN_IDLE,            32'h0,         6'b000000, 32'h0));

    reset = 1'b1;
    {req_valid, req_icache, req_tlb, ifu_idle, lsu_idle,
     icache_flush_ack, tlb_flush_ack, redirect_ready} = IN_IDLE;
    req_dnpc = 32'h0;
    #1;
    chk("reset_flags", {58'h0, busy, pipe_kill, icache_flush_req, tlb_flush_req, redirect_valid, flush_err}, 64'h0);
    chk("reset_pc", {32'h0, redirect_pc}, 64'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < split_a; i++) apply_vec(i, vecs[i]);

    // reset asserted while both invalidations are pending
    @(negedge clock);
    {req_valid, req_icache, req_tlb} = 3'b111;
    req_dnpc = 32'h8000_0700;
    @(negedge clock);
    {req_valid, req_icache, req_tlb} = 3'b000;
    @(negedge clock);
    #1;
    chk("preflush_reqs", {60'h0, icache_flush_req, tlb_flush_req, pipe_kill, flush_err}, 64'hF);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_flags", {58'h0, busy, pipe_kill, icache_flush_req, tlb_flush_req, redirect_valid, flush_err}, 64'h0);
    chk("midreset_pc", {32'h0, redirect_pc}, 64'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = split_a; i < vecs.size(); i++) apply_vec(i, vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
